// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite compositor.
//   sprite_t   - architectural state of one sprite channel (position,
//                velocity, colour, enable). Deltas are carried at the
//                widest supported width (8 bits); each channel keeps only
//                its low DELTA_W bits.
//   COLOR_W    - {B,G,R} colour width, 4 bits per component.
//   BG_DEFAULT - default background colour.
package sprite_pkg;

    localparam int COLOR_W  = 12;
    localparam int PX_W     = 11;
    localparam int PY_W     = 10;
    localparam int DMAX_W   = 8;
    localparam logic [COLOR_W-1:0] BG_DEFAULT = 12'h000;

    typedef struct packed {
        logic [PX_W-1:0]          pos_x;
        logic [PY_W-1:0]          pos_y;
        logic signed [DMAX_W-1:0] dx;
        logic signed [DMAX_W-1:0] dy;
        logic [COLOR_W-1:0]       color;
        logic                     en;
    } sprite_t;

endpackage

// File: rtl/sprite_motion.sv
// sprite_motion: state registers and per-frame bounce arithmetic of one
// sprite channel.
//   clk, rst - pixel clock, synchronous active-high reset (clears all, en=0)
//   we       - load every field from cfg; wins over tick
//   tick     - one-cycle frame pulse; moves the sprite when enabled
//   cfg      - configuration word (dx/dy sign-extended to 8 bits)
//   spr      - current state, dx/dy sign-extended to 8 bits
module sprite_motion
    import sprite_pkg::*;
#(
    parameter int DELTA_W = 4,
    parameter int LIM_X   = 768,
    parameter int LIM_Y   = 568
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    we,
    input  logic    tick,
    input  sprite_t cfg,
    output sprite_t spr
);

    localparam logic signed [11:0]      LIM_XS = 12'(LIM_X);
    localparam logic signed [11:0]      LIM_YS = 12'(LIM_Y);
    localparam logic [DELTA_W-1:0]      D_MIN  = {1'b1, {(DELTA_W-1){1'b0}}};

    logic [PX_W-1:0]           pos_x;
    logic [PY_W-1:0]           pos_y;
    logic signed [DELTA_W-1:0] dx, dy;
    logic [COLOR_W-1:0]        color;
    logic                      en;
    logic signed [11:0]        new_x, new_y;
    logic                      unused_cfg_bits;

    // The most negative delta has no positive twin; clamp to the largest.
    function automatic logic signed [DELTA_W-1:0] neg_sat(input logic signed [DELTA_W-1:0] d);
        if (d == D_MIN) return $signed(~D_MIN);
        return -d;
    endfunction

    assign new_x = $signed({1'b0, pos_x}) + 12'(dx);
    assign new_y = $signed({2'b0, pos_y}) + 12'(dy);

    // Upper delta bits beyond DELTA_W are don't-care.
    assign unused_cfg_bits = ^{cfg.dx, cfg.dy};

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x <= '0;
            pos_y <= '0;
            dx    <= '0;
            dy    <= '0;
            color <= '0;
            en    <= 1'b0;
        end else if (we) begin
            pos_x <= cfg.pos_x;
            pos_y <= cfg.pos_y;
            dx    <= cfg.dx[DELTA_W-1:0];
            dy    <= cfg.dy[DELTA_W-1:0];
            color <= cfg.color;
            en    <= cfg.en;
        end else if (tick && en) begin
            if (new_x[11]) begin
                pos_x <= '0;
                dx    <= neg_sat(dx);
            end else if (new_x > LIM_XS) begin
                pos_x <= PX_W'(LIM_X);
                dx    <= neg_sat(dx);
            end else begin
                pos_x <= new_x[PX_W-1:0];
            end

            if (new_y[11]) begin
                pos_y <= '0;
                dy    <= neg_sat(dy);
            end else if (new_y > LIM_YS) begin
                pos_y <= PY_W'(LIM_Y);
                dy    <= neg_sat(dy);
            end else begin
                pos_y <= new_y[PY_W-1:0];
            end
        end
    end

    assign spr.pos_x = pos_x;
    assign spr.pos_y = pos_y;
    assign spr.dx    = DMAX_W'(dx);
    assign spr.dy    = DMAX_W'(dy);
    assign spr.color = color;
    assign spr.en    = en;

endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: N_SPR bouncing rectangular sprites composited over a
// background colour on a VGA beam, with a fixed 2-cycle pipeline.
//   clk, rst               - pixel clock, synchronous active-high reset
//   beam_x, beam_y, valid  - beam position, visible-area flag
//   switch_line            - hsync in (delayed 2 cycles to VGA_HS)
//   switch_frame           - vsync in, active-low; its fall moves sprites
//   cfg_*                  - sprite configuration write port
//   VGA_R/G/B              - composited colour ({B,G,R} order internally)
//   VGA_HS, VGA_VS         - syncs aligned with the colour
//   hit_mask               - per-sprite coverage of the output pixel
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int N_SPR   = 4,
    parameter int SPR_W   = 32,
    parameter int SPR_H   = 32,
    parameter int SCR_W   = 800,
    parameter int SCR_H   = 600,
    parameter int DELTA_W = 4,
    parameter logic [COLOR_W-1:0] BG_COLOR = BG_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [10:0]               beam_x,
    input  logic [9:0]                beam_y,
    input  logic                      valid,
    input  logic                      switch_line,
    input  logic                      switch_frame,
    input  logic                      cfg_we,
    input  logic [2:0]                cfg_idx,
    input  logic [10:0]               cfg_x,
    input  logic [9:0]                cfg_y,
    input  logic signed [DELTA_W-1:0] cfg_dx,
    input  logic signed [DELTA_W-1:0] cfg_dy,
    input  logic [11:0]               cfg_color,
    input  logic                      cfg_en,
    output logic [3:0]                VGA_R,
    output logic [3:0]                VGA_G,
    output logic [3:0]                VGA_B,
    output logic                      VGA_HS,
    output logic                      VGA_VS,
    output logic [N_SPR-1:0]          hit_mask
);

    localparam int STAGES = 2;

    sprite_t            cfg_word;
    sprite_t            spr [N_SPR];
    logic               vs_q, frame_tick;
    logic [N_SPR-1:0]   hit_c, hit_s1;
    logic [STAGES:1]    vld_pipe, hs_pipe, vs_pipe;
    logic [COLOR_W-1:0] pick, color_q;

    assign cfg_word.pos_x = cfg_x;
    assign cfg_word.pos_y = cfg_y;
    assign cfg_word.dx    = DMAX_W'(cfg_dx);
    assign cfg_word.dy    = DMAX_W'(cfg_dy);
    assign cfg_word.color = cfg_color;
    assign cfg_word.en    = cfg_en;

    // Frame tick on the fall of switch_frame. The history bit clears to 0,
    // so a vsync already low when reset releases cannot produce a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q       <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vs_q       <= switch_frame;
            frame_tick <= vs_q & ~switch_frame;
        end
    end

    for (genvar g = 0; g < N_SPR; g++) begin : g_spr
        logic unused_delta;

        // Indices >= N_SPR match no channel, so such writes are dropped.
        sprite_motion #(
            .DELTA_W (DELTA_W),
            .LIM_X   (SCR_W - SPR_W),
            .LIM_Y   (SCR_H - SPR_H)
        ) u_motion (
            .clk  (clk),
            .rst  (rst),
            .we   (cfg_we && (cfg_idx == 3'(g))),
            .tick (frame_tick),
            .cfg  (cfg_word),
            .spr  (spr[g])
        );

        assign unused_delta = ^{spr[g].dx, spr[g].dy};
    end

    // Box test, widened by one bit so pos+size cannot wrap.
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < N_SPR; i++) begin
            hit_c[i] = spr[i].en
                && (beam_x >= spr[i].pos_x)
                && ({1'b0, beam_x} < ({1'b0, spr[i].pos_x} + 12'(SPR_W)))
                && (beam_y >= spr[i].pos_y)
                && ({1'b0, beam_y} < ({1'b0, spr[i].pos_y} + 11'(SPR_H)));
        end
    end

    // Lowest index wins: scan downward so the last assignment sticks.
    always_comb begin
        pick = BG_COLOR;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (hit_s1[i]) pick = spr[i].color;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
            hit_s1   <= '0;
            hit_mask <= '0;
            color_q  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], valid};
            hs_pipe  <= {hs_pipe[STAGES-1:1], switch_line};
            vs_pipe  <= {vs_pipe[STAGES-1:1], switch_frame};
            hit_s1   <= hit_c;
            hit_mask <= hit_s1;
            color_q  <= vld_pipe[1] ? pick : '0;
        end
    end

    assign VGA_R  = color_q[3:0];
    assign VGA_G  = color_q[7:4];
    assign VGA_B  = color_q[11:8];
    assign VGA_HS = hs_pipe[STAGES];
    assign VGA_VS = vs_pipe[STAGES];

endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;

    localparam int N     = 4;
    localparam int SW    = 32;
    localparam int SH    = 32;
    localparam int LIMX  = 800 - 32;
    localparam int LIMY  = 600 - 32;
    localparam logic [11:0] BG = 12'h000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [10:0] beam_x = '0;
    logic [9:0]  beam_y = '0;
    logic valid = 1'b0, switch_line = 1'b1, switch_frame = 1'b1;
    logic cfg_we = 1'b0, cfg_en = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [10:0] cfg_x = '0;
    logic [9:0]  cfg_y = '0;
    logic signed [3:0] cfg_dx = '0, cfg_dy = '0;
    logic [11:0] cfg_color = '0;
    logic [3:0]  VGA_R, VGA_G, VGA_B;
    logic VGA_HS, VGA_VS;
    logic [N-1:0] hit_mask;

    int vectors = 0;
    int miscompares = 0;

    // Reference state of every sprite
    int mx[N], my[N], mdx[N], mdy[N];
    logic [11:0] mcol[N];
    bit men[N];

    always #5 clk = ~clk;

    sprite_compositor #(
        .N_SPR(N), .SPR_W(SW), .SPR_H(SH), .SCR_W(800), .SCR_H(600),
        .DELTA_W(4), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst), .beam_x(beam_x), .beam_y(beam_y), .valid(valid),
        .switch_line(switch_line), .switch_frame(switch_frame),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_dx(cfg_dx), .cfg_dy(cfg_dy), .cfg_color(cfg_color), .cfg_en(cfg_en),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .hit_mask(hit_mask)
    );

    // ---------------- reference model ----------------
    function automatic bit covers(int i, int bx, int by);
        return men[i] && bx >= mx[i] && bx < mx[i] + SW && by >= my[i] && by < my[i] + SH;
    endfunction

    function automatic logic [11:0] exp_col(int bx, int by, bit v);
        if (!v) return 12'h000;
        for (int i = 0; i < N; i++) if (covers(i, bx, by)) return mcol[i];
        return BG;
    endfunction

    function automatic logic [N-1:0] exp_mask(int bx, int by);
        logic [N-1:0] m = '0;
        for (int i = 0; i < N; i++) m[i] = covers(i, bx, by);
        return m;
    endfunction

    function automatic int neg_sat(int d);
        return (d == -8) ? 7 : -d;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0; mcol[i] = 0; men[i] = 0;
        end
    endtask

    task automatic model_tick(input int skip);
        int nx, ny;
        for (int i = 0; i < N; i++) begin
            if (men[i] && i != skip) begin
                nx = mx[i] + mdx[i];
                ny = my[i] + mdy[i];
                if (nx < 0)         begin mx[i] = 0;    mdx[i] = neg_sat(mdx[i]); end
                else if (nx > LIMX) begin mx[i] = LIMX; mdx[i] = neg_sat(mdx[i]); end
                else                mx[i] = nx;
                if (ny < 0)         begin my[i] = 0;    mdy[i] = neg_sat(mdy[i]); end
                else if (ny > LIMY) begin my[i] = LIMY; mdy[i] = neg_sat(mdy[i]); end
                else                my[i] = ny;
            end
        end
    endtask

    task automatic model_write(int idx, int x, int y, int dx, int dy, logic [11:0] col, bit en);
        if (idx < N) begin
            mx[idx] = x; my[idx] = y; mdx[idx] = dx; mdy[idx] = dy;
            mcol[idx] = col; men[idx] = en;
        end
    endtask

    // ---------------- stimulus drivers ----------------
    task automatic drive_cfg(int idx, int x, int y, int dx, int dy, logic [11:0] col, bit en);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_x = 11'(x); cfg_y = 10'(y);
        cfg_dx = 4'(dx); cfg_dy = 4'(dy); cfg_color = col; cfg_en = en;
    endtask

    task automatic write_cfg(int idx, int x, int y, int dx, int dy, logic [11:0] col, bit en);
        @(negedge clk);
        drive_cfg(idx, x, y, dx, dy, col, en);
        @(negedge clk);
        cfg_we = 1'b0;
        model_write(idx, x, y, dx, dy, col, en);
    endtask

    task automatic frame_pulse();
        @(negedge clk); switch_frame = 1'b0;
        @(negedge clk);
        @(negedge clk); switch_frame = 1'b1;
        model_tick(-1);
    endtask

    // Hold one beam position until it has crossed both pipeline stages.
    task automatic probe(int bx, int by, bit v);
        @(negedge clk);
        beam_x = 11'(bx); beam_y = 10'(by); valid = v;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic disable_all();
        for (int i = 0; i < N; i++) write_cfg(i, 0, 0, 0, 0, 12'h000, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; switch_line = 1'b0; switch_frame = 1'b0; valid = 1'b1;
        beam_x = 11'd5; beam_y = 10'd5;
        repeat (3) @(negedge clk);
        vectors += 4;
        if ({VGA_B, VGA_G, VGA_R} !== 12'h000) begin miscompares++; $display("FAIL reset_rgb got=%h exp=000", {VGA_B, VGA_G, VGA_R}); end
        if (hit_mask !== 4'b0000) begin miscompares++; $display("FAIL reset_mask got=%b exp=0000", hit_mask); end
        if (VGA_HS !== 1'b1) begin miscompares++; $display("FAIL reset_hs got=%b exp=1", VGA_HS); end
        if (VGA_VS !== 1'b1) begin miscompares++; $display("FAIL reset_vs got=%b exp=1", VGA_VS); end
        switch_line = 1'b1; switch_frame = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_clear();
    endtask

    task automatic test_hit();
        int px[6] = '{100, 132, 131, 100, 99, 140};
        int py[6] = '{50, 50, 81, 82, 50, 60};
        write_cfg(0, 100, 50, 0, 0, 12'hF00, 1'b1);
        // out-of-range index must be ignored
        write_cfg(4, 130, 55, 0, 0, 12'h0F0, 1'b1);
        write_cfg(5, 136, 55, 0, 0, 12'h00F, 1'b1);
        foreach (px[k]) begin
            probe(px[k], py[k], 1'b1);
            vectors += 2;
            if ({VGA_B, VGA_G, VGA_R} !== exp_col(px[k], py[k], 1'b1)) begin
                miscompares++;
                $display("FAIL hit_color(%0d,%0d) got=%h exp=%h", px[k], py[k], {VGA_B, VGA_G, VGA_R}, exp_col(px[k], py[k], 1'b1));
            end
            if (hit_mask !== exp_mask(px[k], py[k])) begin
                miscompares++;
                $display("FAIL hit_mask(%0d,%0d) got=%b exp=%b", px[k], py[k], hit_mask, exp_mask(px[k], py[k]));
            end
        end
    endtask

    task automatic test_overlap();
        int px[4] = '{200, 215, 188, 221};
        int py[4] = '{200, 221, 195, 226};
        write_cfg(0, 185, 195, 0, 0, 12'hF00, 1'b1);
        write_cfg(2, 190, 190, 0, 0, 12'h0F0, 1'b1);
        write_cfg(3, 210, 220, 0, 0, 12'h00F, 1'b1);
        foreach (px[k]) begin
            probe(px[k], py[k], 1'b1);
            vectors += 2;
            if ({VGA_B, VGA_G, VGA_R} !== exp_col(px[k], py[k], 1'b1)) begin
                miscompares++;
                $display("FAIL overlap_color(%0d,%0d) got=%h exp=%h", px[k], py[k], {VGA_B, VGA_G, VGA_R}, exp_col(px[k], py[k], 1'b1));
            end
            if (hit_mask !== exp_mask(px[k], py[k])) begin
                miscompares++;
                $display("FAIL overlap_mask(%0d,%0d) got=%b exp=%b", px[k], py[k], hit_mask, exp_mask(px[k], py[k]));
            end
        end
    endtask

    task automatic test_blank_sync();
        bit hs_h[16], vs_h[16];
        bit sf_prev;
        probe(200, 200, 1'b0);
        vectors += 2;
        if ({VGA_B, VGA_G, VGA_R} !== 12'h000) begin miscompares++; $display("FAIL blank_rgb got=%h exp=000", {VGA_B, VGA_G, VGA_R}); end
        if (hit_mask !== exp_mask(200, 200)) begin miscompares++; $display("FAIL blank_mask got=%b exp=%b", hit_mask, exp_mask(200, 200)); end
        sf_prev = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                vectors += 2;
                if (VGA_HS !== hs_h[i-2]) begin miscompares++; $display("FAIL hs_delay[%0d] got=%b exp=%b", i, VGA_HS, hs_h[i-2]); end
                if (VGA_VS !== vs_h[i-2]) begin miscompares++; $display("FAIL vs_delay[%0d] got=%b exp=%b", i, VGA_VS, vs_h[i-2]); end
            end
            hs_h[i] = 1'($urandom);
            vs_h[i] = (i < 13) ? 1'($urandom) : 1'b1;
            switch_line = hs_h[i]; switch_frame = vs_h[i];
            if (sf_prev && !vs_h[i]) model_tick(-1);
            sf_prev = vs_h[i];
        end
        @(negedge clk); switch_line = 1'b1; switch_frame = 1'b1;
    endtask

    task automatic test_bounce();
        int px[4] = '{768, 767, 0, 7};
        int py[4] = '{100, 100, 300, 300};
        disable_all();
        write_cfg(1, 766, 100, 5, 0, 12'h00F, 1'b1);
        write_cfg(3, 4, 300, -8, 0, 12'h0F0, 1'b1);
        frame_pulse();   // x1: 768 dx -5 ; x3: 0 dx +7
        foreach (px[k]) begin
            probe(px[k], py[k], 1'b1);
            vectors += 1;
            if (hit_mask !== exp_mask(px[k], py[k])) begin
                miscompares++;
                $display("FAIL bounce1_mask(%0d,%0d) got=%b exp=%b", px[k], py[k], hit_mask, exp_mask(px[k], py[k]));
            end
        end
        frame_pulse();   // x1: 763 ; x3: 7
        px = '{763, 762, 7, 6};
        foreach (px[k]) begin
            probe(px[k], py[k], 1'b1);
            vectors += 1;
            if (hit_mask !== exp_mask(px[k], py[k])) begin
                miscompares++;
                $display("FAIL bounce2_mask(%0d,%0d) got=%b exp=%b", px[k], py[k], hit_mask, exp_mask(px[k], py[k]));
            end
        end
    endtask

    task automatic test_collision();
        int px[5] = '{303, 302, 500, 402, 499};
        int py[5] = '{300, 300, 310, 301, 310};
        disable_all();
        write_cfg(0, 300, 300, 3, 0, 12'hF00, 1'b1);
        write_cfg(1, 400, 300, 2, 1, 12'h0F0, 1'b1);
        @(negedge clk); switch_frame = 1'b0;
        @(negedge clk); drive_cfg(1, 500, 310, -3, 2, 12'h00F, 1'b1);   // lands in the tick cycle
        @(negedge clk); cfg_we = 1'b0; switch_frame = 1'b1;
        model_tick(1);
        model_write(1, 500, 310, -3, 2, 12'h00F, 1'b1);
        foreach (px[k]) begin
            probe(px[k], py[k], 1'b1);
            vectors += 2;
            if ({VGA_B, VGA_G, VGA_R} !== exp_col(px[k], py[k], 1'b1)) begin
                miscompares++;
                $display("FAIL collide_color(%0d,%0d) got=%h exp=%h", px[k], py[k], {VGA_B, VGA_G, VGA_R}, exp_col(px[k], py[k], 1'b1));
            end
            if (hit_mask !== exp_mask(px[k], py[k])) begin
                miscompares++;
                $display("FAIL collide_mask(%0d,%0d) got=%b exp=%b", px[k], py[k], hit_mask, exp_mask(px[k], py[k]));
            end
        end
    endtask

    // Back-to-back random beams against random moving sprites.
    task automatic test_back_to_back();
        logic [11:0] qc[$];
        logic [N-1:0] qm[$];
        bit qh[$], qv[$];
        for (int i = 0; i < N; i++)
            write_cfg(i, $urandom_range(0, LIMX), $urandom_range(0, LIMY),
                      int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                      12'($urandom), ($urandom_range(0, 3) != 0));
        for (int f = 0; f < 6; f++) begin
            frame_pulse();
            for (int i = 0; i < 42; i++) begin
                @(negedge clk);
                if (i >= 2) begin
                    logic [11:0] ec; logic [N-1:0] em; bit eh;
                    ec = qc.pop_front(); em = qm.pop_front(); eh = qh.pop_front();
                    vectors += 3;
                    if ({VGA_B, VGA_G, VGA_R} !== ec) begin miscompares++; $display("FAIL b2b_color f%0d c%0d got=%h exp=%h", f, i, {VGA_B, VGA_G, VGA_R}, ec); end
                    if (hit_mask !== em) begin miscompares++; $display("FAIL b2b_mask f%0d c%0d got=%b exp=%b", f, i, hit_mask, em); end
                    if (VGA_HS !== eh) begin miscompares++; $display("FAIL b2b_hs f%0d c%0d got=%b exp=%b", f, i, VGA_HS, eh); end
                end
                if (i < 40) begin
                    int k, bx, by; bit v, sl;
                    k  = $urandom_range(0, N - 1);
                    bx = mx[k] + int'($urandom_range(0, SW + 7)) - 4;
                    by = my[k] + int'($urandom_range(0, SH + 7)) - 4;
                    if (bx < 0) bx = 0;
                    if (by < 0) by = 0;
                    v  = ($urandom_range(0, 7) != 0);
                    sl = 1'($urandom);
                    beam_x = 11'(bx); beam_y = 10'(by); valid = v; switch_line = sl;
                    qc.push_back(exp_col(bx, by, v));
                    qm.push_back(exp_mask(bx, by));
                    qh.push_back(sl);
                    qv.push_back(v);
                end
            end
            switch_line = 1'b1;
        end
    endtask

    task automatic test_mid_reset();
        int px[2];
        write_cfg(0, 100, 100, 0, 0, 12'hF00, 1'b1);
        @(negedge clk);
        beam_x = 11'd100; beam_y = 10'd100; valid = 1'b1;
        switch_frame = 1'b0; switch_line = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        vectors += 4;
        if ({VGA_B, VGA_G, VGA_R} !== 12'h000) begin miscompares++; $display("FAIL midrst_rgb got=%h exp=000", {VGA_B, VGA_G, VGA_R}); end
        if (hit_mask !== 4'b0000) begin miscompares++; $display("FAIL midrst_mask got=%b exp=0000", hit_mask); end
        if (VGA_HS !== 1'b1) begin miscompares++; $display("FAIL midrst_hs got=%b exp=1", VGA_HS); end
        if (VGA_VS !== 1'b1) begin miscompares++; $display("FAIL midrst_vs got=%b exp=1", VGA_VS); end
        rst = 1'b0; switch_line = 1'b1;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        vectors += 2;
        if ({VGA_B, VGA_G, VGA_R} !== exp_col(100, 100, 1'b1)) begin miscompares++; $display("FAIL postrst_color got=%h exp=%h", {VGA_B, VGA_G, VGA_R}, exp_col(100, 100, 1'b1)); end
        if (hit_mask !== exp_mask(100, 100)) begin miscompares++; $display("FAIL postrst_mask got=%b exp=%b", hit_mask, exp_mask(100, 100)); end
        // vsync still low since reset: no tick may move this sprite
        write_cfg(0, 100, 100, 4, 0, 12'h0FF, 1'b1);
        repeat (4) @(negedge clk);
        px = '{100, 99};
        foreach (px[k]) begin
            probe(px[k], 100, 1'b1);
            vectors += 1;
            if (hit_mask !== exp_mask(px[k], 100)) begin miscompares++; $display("FAIL notick_mask(%0d) got=%b exp=%b", px[k], hit_mask, exp_mask(px[k], 100)); end
        end
        @(negedge clk); switch_frame = 1'b1;
        frame_pulse();
        px = '{104, 103};
        foreach (px[k]) begin
            probe(px[k], 100, 1'b1);
            vectors += 1;
            if (hit_mask !== exp_mask(px[k], 100)) begin miscompares++; $display("FAIL retick_mask(%0d) got=%b exp=%b", px[k], hit_mask, exp_mask(px[k], 100)); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_hit();
        test_overlap();
        test_blank_sync();
        test_bounce();
        test_collision();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter N_SPR, default 4: number of sprite channels, 1..8.
REQ-002 SHALL have parameter SPR_W / SPR_H, default 32 / 32: sprite box size in pixels.
REQ-003 SHALL have parameter SCR_W / SCR_H, default 800 / 600: visible area size.
REQ-004 SHALL have parameter DELTA_W, default 4: signed per-frame velocity width.
REQ-005 SHALL have parameter BG_COLOR, default 12'h000: background {B,G,R} colour, 4 bits each.
REQ-006 SHALL have one clock and a synchronous, active-high reset; ports clk, rst.
REQ-007 SHALL have ports: clk in 1 pixel clock; rst in 1 synchronous active-high reset.
REQ-008 SHALL have ports: beam_x in 11; beam_y in 10; valid in 1 (beam inside visible area).
REQ-009 SHALL have ports: switch_line in 1 (hsync); switch_frame in 1 (vsync, active-low pulse).
REQ-010 SHALL have ports: cfg_we in 1; cfg_idx in 3; cfg_x in 11; cfg_y in 10; cfg_dx in DELTA_W signed; cfg_dy in DELTA_W signed; cfg_color in 12; cfg_en in 1.
REQ-011 SHALL have ports: VGA_R, VGA_G, VGA_B out 4 each; VGA_HS out 1; VGA_VS out 1; hit_mask out N_SPR (per-sprite coverage of the pixel currently output).

Function
REQ-012 SHALL hold per-sprite registers: pos_x (11), pos_y (10), dx, dy (DELTA_W signed), color (12), en (1).
REQ-013 SHALL load all six fields of sprite cfg_idx when cfg_we=1; SHALL ignore the write if cfg_idx >= N_SPR.
REQ-014 SHALL generate frame_tick, a one-cycle pulse, on the registered falling edge of switch_frame.
REQ-015 SHALL, on frame_tick, set new_x = pos_x + sign-extended dx for each enabled sprite, computed 12 bits signed; likewise for y.
REQ-016 SHALL bounce on the x axis: if new_x < 0, pos_x=0 and dx=-dx; if new_x > SCR_W-SPR_W, pos_x=SCR_W-SPR_W and dx=-dx; otherwise pos_x=new_x. The y axis SHALL bounce identically against SCR_H-SPR_H.
REQ-017 SHALL saturate negation of the most-negative delta (-8 becomes +7 at DELTA_W=4).
REQ-018 SHALL give the config write priority when cfg_we and frame_tick coincide on the same index; the other sprites SHALL still update.
REQ-019 SHALL leave disabled sprites unchanged on frame_tick and exclude them from hits.
REQ-020 SHALL, in stage 1, register hit[i] = en & (pos_x <= beam_x < pos_x+SPR_W) & (pos_y <= beam_y < pos_y+SPR_H), plus valid.
REQ-021 SHALL, in stage 2, register the colour of the lowest-index hit sprite, else BG_COLOR; the colour SHALL be 0 when the delayed valid=0.
REQ-022 SHALL have a fixed 2-cycle latency from beam inputs to colour outputs.
REQ-023 SHALL delay VGA_HS, VGA_VS and hit_mask by 2 cycles so they align with the colour outputs.
REQ-024 SHALL perform hit tests against positions that are stable for the whole visible frame; updates occur only during vsync.

Reset
REQ-025 SHALL, with rst=1 at a clk edge, clear every sprite register to 0, including en=0.
REQ-026 SHALL, during reset, drive VGA_R/G/B = 0, hit_mask = 0, VGA_HS = 1, VGA_VS = 1, clear the pipeline, and clear the edge detector.
REQ-027 SHALL restart cleanly when reset is asserted mid-frame; the first output after release SHALL be valid 2 cycles later.

Structure
REQ-028 SHALL place in package sprite_pkg: the sprite_t struct (pos, delta, colour, en), the colour width constant, and the BG default.
REQ-029 SHALL use one sub-module, sprite_motion, instantiated N_SPR times, holding the registers and the bounce arithmetic of one sprite.
REQ-030 SHALL have RTL of 150-350 lines in total.

Verification
REQ-031 SHALL verify a hit: sprite0 at (100,50), colour 12'hF00, en; beam (100,50) valid -> colour F00 two cycles later and hit_mask=0001; beam (132,50) -> BG.
REQ-032 SHALL verify overlap: sprite0 and sprite2 both cover (200,200) -> sprite0's colour and hit_mask=0101.
REQ-033 SHALL verify bounce: sprite1 pos_x=766, dx=+5 with SCR_W-SPR_W=768, one frame_tick -> pos_x=768, dx=-5; next tick -> 763.
REQ-034 SHALL verify collision of write and tick: cfg_we to idx1 in the frame_tick cycle -> written values are kept without the delta; sprite0 still moves.
REQ-035 SHALL verify blanking and sync: valid=0 -> RGB=0; VGA_HS equals switch_line delayed exactly 2 cycles.
REQ-036 SHALL verify reset: rst mid-frame -> all sprites disabled, outputs 0, no frame_tick until the next switch_frame fall.
